// File: rtl/lfsr_rand_gen.sv
// Galois LFSR with seed load and zero-lockup guard, plus a rejection-sampling draw engine.
// Latency: req accepted in cycle N gives valid in N+2 at best, longer on rejections or reduction.
// Backpressure: none. req is ignored while busy, and valid is a one-cycle pulse with no ready.
module lfsr_rand_gen #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
    parameter int               OUT_W        = 8,
    parameter int               MAX_TRIES    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             req,
    input  logic [OUT_W-1:0] limit,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] rand_out,
    output logic             fallback,
    output logic             q
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, DRAW, REDUCE} fsm_t;

    fsm_t             fsm, fsm_nxt;
    logic [WIDTH-1:0] lfsr, lfsr_step, lfsr_nxt;
    logic [OUT_W-1:0] lim_r, lim_nxt;
    logic [OUT_W-1:0] w, w_nxt;
    logic [OUT_W-1:0] rand_nxt, cand;
    logic [TW-1:0]    tries, tries_nxt;
    logic             valid_nxt, fb_nxt;

    // A zero state would lock the register up, whether it came from a seed or a bad tap mask.
    always_comb begin
        lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        lfsr_nxt  = load ? seed : lfsr_step;
        if (lfsr_nxt == '0) begin
            lfsr_nxt = DEFAULT_SEED;
        end
    end

    assign cand = lfsr[OUT_W-1:0];

    always_comb begin
        fsm_nxt   = fsm;
        lim_nxt   = lim_r;
        tries_nxt = tries;
        w_nxt     = w;
        rand_nxt  = rand_out;
        fb_nxt    = fallback;
        valid_nxt = 1'b0;
        case (fsm)
            IDLE: begin
                if (req) begin
                    lim_nxt   = limit;
                    tries_nxt = '0;
                    fsm_nxt   = DRAW;
                end
            end
            DRAW: begin
                if ((lim_r == '0) || (cand < lim_r)) begin
                    rand_nxt  = cand;
                    fb_nxt    = 1'b0;
                    valid_nxt = 1'b1;
                    fsm_nxt   = IDLE;
                end else if (tries == LAST_TRY) begin
                    w_nxt   = cand;
                    fsm_nxt = REDUCE;
                end else begin
                    tries_nxt = tries + TW'(1);
                end
            end
            REDUCE: begin
                // Repeated subtraction: w stays >= lim_r on this branch, so it never underflows.
                if (w < lim_r) begin
                    rand_nxt  = w;
                    fb_nxt    = 1'b1;
                    valid_nxt = 1'b1;
                    fsm_nxt   = IDLE;
                end else begin
                    w_nxt = w - lim_r;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= DEFAULT_SEED;
            fsm      <= IDLE;
            lim_r    <= '0;
            tries    <= '0;
            w        <= '0;
            rand_out <= '0;
            fallback <= 1'b0;
            valid    <= 1'b0;
        end else begin
            lfsr     <= lfsr_nxt;
            fsm      <= fsm_nxt;
            lim_r    <= lim_nxt;
            tries    <= tries_nxt;
            w        <= w_nxt;
            rand_out <= rand_nxt;
            fallback <= fb_nxt;
            valid    <= valid_nxt;
        end
    end

    assign busy = (fsm != IDLE);
    assign q    = lfsr[0];

endmodule
